// File: rtl/adder_seq_if.sv
// Valid/ready bundle for the shared sequential adder: two requesters and one result consumer.
interface adder_seq_if #(
  parameter int WORDS  = 4,
  parameter int WORD_W = 8
);
  localparam int W = WORDS * WORD_W;

  logic         r0_valid;
  logic         r0_ready;
  logic [W-1:0] r0_a;
  logic [W-1:0] r0_b;
  logic         r0_sub;
  logic         r1_valid;
  logic         r1_ready;
  logic [W-1:0] r1_a;
  logic [W-1:0] r1_b;
  logic         r1_sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  modport master (
    output r0_valid, r0_a, r0_b, r0_sub,
    output r1_valid, r1_a, r1_b, r1_sub,
    output res_ready,
    input  r0_ready, r1_ready,
    input  res_valid, res_sum, res_cout, res_id
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_sub,
    input  r1_valid, r1_a, r1_b, r1_sub,
    input  res_ready,
    output r0_ready, r1_ready,
    output res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/adder_seq_arbiter.sv
// Round-robin shares one WORD_W-bit adder slice between two requesters, LS word first.
// Define ADDER_SEQ_SUB_EN to honour r*_sub (A-B); otherwise the unit only adds.
module adder_seq_arbiter #(
  parameter int WORDS  = 4,
  parameter int WORD_W = 8
) (
  input logic         clk,
  input logic         rst,
  adder_seq_if.slave  bus
);
  localparam int W     = WORDS * WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_q, b_q;
  logic               id_q;
  logic               carry;
  logic               last_id;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               res_id_q;

  logic               gnt0, gnt1, accept, last_word;
  logic [WORD_W-1:0]  a_word, b_word, b_eff;
  logic [WORD_W:0]    sum_word;

  // Tie goes to whoever was not served last; exclusive by construction.
  assign gnt0   = (state == IDLE) & bus.r0_valid & (~bus.r1_valid | last_id);
  assign gnt1   = (state == IDLE) & bus.r1_valid & (~bus.r0_valid | ~last_id);
  assign accept = gnt0 | gnt1;

  assign last_word = (idx == IDX_W'(WORDS - 1));

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IDX_W'(w)) begin
        a_word = a_q[w*WORD_W +: WORD_W];
        b_word = b_q[w*WORD_W +: WORD_W];
      end
    end
  end

`ifdef ADDER_SEQ_SUB_EN
  logic sub_q;
  assign b_eff = sub_q ? ~b_word : b_word;
`else
  logic unused_sub;
  assign unused_sub = bus.r0_sub ^ bus.r1_sub;
  assign b_eff = b_word;
`endif

  assign sum_word = {1'b0, a_word} + {1'b0, b_eff} + (WORD_W+1)'(carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_word) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      carry    <= 1'b0;
      last_id  <= 1'b1;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      res_id_q <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= gnt1 ? bus.r1_a : bus.r0_a;
            b_q     <= gnt1 ? bus.r1_b : bus.r0_b;
            id_q    <= gnt1;
            last_id <= gnt1;
            idx     <= '0;
`ifdef ADDER_SEQ_SUB_EN
            sub_q   <= gnt1 ? bus.r1_sub : bus.r0_sub;
            carry   <= gnt1 ? bus.r1_sub : bus.r0_sub;
`else
            carry   <= 1'b0;
`endif
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) sum_q[w*WORD_W +: WORD_W] <= sum_word[WORD_W-1:0];
          end
          carry <= sum_word[WORD_W];
          if (last_word) begin
            cout_q   <= sum_word[WORD_W];
            res_id_q <= id_q;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.r0_ready  = gnt0;
  assign bus.r1_ready  = gnt1;
  assign bus.res_valid = (state == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Scoreboard bench for adder_seq_arbiter (WORDS=4, WORD_W=8); honours ADDER_SEQ_SUB_EN.
module tb_adder_seq_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_seq_if #(.WORDS(4), .WORD_W(8)) bus();
  adder_seq_arbiter #(.WORDS(4), .WORD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        id;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] t_a0[2], t_b0[2], t_s0[2], t_a1[2], t_b1[2], t_s1[2];
  logic        t_c0[2], t_c1[2];
  logic        exp_order[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", bus.res_sum);
        end else begin
          e = sb.pop_front();
          check("res_sum", 64'(bus.res_sum), 64'(e.sum));
          check("res_cout", 64'(bus.res_cout), 64'(e.cout));
          check("res_id", 64'(bus.res_id), 64'(e.id));
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] s, input logic c, input logic id);
    exp_t e;
    e.sum = s; e.cout = c; e.id = id;
    sb.push_back(e);
  endtask

  // Present one operation and return #1 after its accept edge.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic push,
                       input logic [31:0] es, input logic ec);
    int cyc = 0;
    if (id) begin
      bus.r1_valid = 1'b1; bus.r1_a = a; bus.r1_b = b; bus.r1_sub = sub;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_a = a; bus.r0_b = b; bus.r0_sub = sub;
    end
    forever begin
      @(negedge clk);
      if ((id ? bus.r1_ready : bus.r0_ready) || cyc >= 50) break;
      cyc++;
    end
    check("accept_timeout", 64'(cyc >= 50), 64'(0));
    if (push) push_exp(es, ec, id);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || bus.res_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", 64'(cyc >= 100), 64'(0));
  endtask

  // Both requesters issue n ops each; accept order checked against exp_order.
  task automatic run_pair(input int n);
    int i0 = 0, i1 = 0, k = 0, cyc = 0;
    bus.res_ready = 1'b1;
    while ((i0 < n || i1 < n) && cyc < 200) begin
      bus.r0_valid = (i0 < n);
      if (i0 < n) begin bus.r0_a = t_a0[i0]; bus.r0_b = t_b0[i0]; end
      bus.r1_valid = (i1 < n);
      if (i1 < n) begin bus.r1_a = t_a1[i1]; bus.r1_b = t_b1[i1]; end
      @(negedge clk);
      check("ready_exclusive", 64'(bus.r0_ready & bus.r1_ready), 64'(0));
      if (bus.r0_ready && k < 4) begin
        check("grant_order", 64'(0), 64'(exp_order[k]));
        push_exp(t_s0[i0], t_c0[i0], 1'b0);
        i0++; k++;
      end else if (bus.r1_ready && k < 4) begin
        check("grant_order", 64'(1), 64'(exp_order[k]));
        push_exp(t_s1[i1], t_c1[i1], 1'b1);
        i1++; k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    check("pair_timeout", 64'(cyc >= 200), 64'(0));
  endtask

  initial begin
    int lat;
    bit ok;
    bus.r0_valid = 0; bus.r0_a = 0; bus.r0_b = 0; bus.r0_sub = 0;
    bus.r1_valid = 0; bus.r1_a = 0; bus.r1_b = 0; bus.r1_sub = 0;
    bus.res_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_res_sum", 64'(bus.res_sum), 64'(0));
    check("rst_res_cout", 64'(bus.res_cout), 64'(0));
    check("rst_res_id", 64'(bus.res_id), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic add, latency
    issue(1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0004, 1'b0);
    wait_valid(lat);
    check("latency", 64'(lat), 64'(4));
    drain();

    // 2: carry ripples through all words
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    drain();

    // 3: continuous tie, round-robin 0,1,0,1
    t_a0[0] = 32'h0000_0092; t_b0[0] = 32'h0000_00AB; t_s0[0] = 32'h0000_013D; t_c0[0] = 1'b0;
    t_a0[1] = 32'h1234_5678; t_b0[1] = 32'h1111_1111; t_s0[1] = 32'h2345_6789; t_c0[1] = 1'b0;
    t_a1[0] = 32'h8000_0092; t_b1[0] = 32'h8000_00AB; t_s1[0] = 32'h0000_013D; t_c1[0] = 1'b1;
    t_a1[1] = 32'h00FF_00FF; t_b1[1] = 32'h0001_0001; t_s1[1] = 32'h0100_0100; t_c1[1] = 1'b0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    run_pair(2);
    drain();

    // 4: consumer stalls 5 cycles in DONE
    bus.res_ready = 1'b0;
    issue(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 1'b0);
    wait_valid(lat);
    bus.r0_valid = 1'b1; bus.r0_a = 32'h1; bus.r0_b = 32'h1;
    bus.r1_valid = 1'b1; bus.r1_a = 32'h2; bus.r1_b = 32'h2;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(bus.res_valid === 1'b1 && bus.res_sum === 32'h0001_0000 &&
            bus.res_cout === 1'b0 && bus.res_id === 1'b0 &&
            bus.r0_ready === 1'b0 && bus.r1_ready === 1'b0)) ok = 1'b0;
    end
    check("stall_stable", 64'(ok), 64'(1));
    @(posedge clk); #1;
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.res_ready = 1'b1;
    drain();

    // 5: reset during RUN idx=2 aborts, then tie goes to r0
    issue(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_res_valid", 64'(bus.res_valid), 64'(0));
    check("abort_res_sum", 64'(bus.res_sum), 64'(0));
    check("abort_res_cout", 64'(bus.res_cout), 64'(0));
    check("abort_res_id", 64'(bus.res_id), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) ok = 1'b0;
    end
    check("abort_no_result", 64'(ok), 64'(1));
    @(posedge clk); #1;
    t_a0[0] = 32'h0000_0003; t_b0[0] = 32'h0000_0004; t_s0[0] = 32'h0000_0007; t_c0[0] = 1'b0;
    t_a1[0] = 32'hFFFF_FFFF; t_b1[0] = 32'hFFFF_FFFF; t_s1[0] = 32'hFFFF_FFFE; t_c1[0] = 1'b1;
    exp_order[0] = 0; exp_order[1] = 1;
    run_pair(1);
    drain();

    // 6: subtract select
`ifdef ADDER_SEQ_SUB_EN
    issue(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    drain();
    issue(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    drain();
`else
    issue(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_000C, 1'b0);
    drain();
    issue(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_000C, 1'b0);
    drain();
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
